// File: rtl/fifo_wr_gen.sv
// Test-pattern write generator for a dual-clock FIFO write port.
// Issues bursts of inc/dec/walking-one/fixed data gated by FIFO flags.
module fifo_wr_gen #(
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         DATA_MAX    = 254,
  parameter logic [DATA_W-1:0]   PATTERN     = DATA_W'(8'hA5)
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [15:0]       burst_len,
  input  logic              wr_rst_busy,
  input  logic              empty,
  input  logic              almost_full,
  input  logic              full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic              burst_done,
  output logic [31:0]       word_cnt,
  output logic              overflow_err
);

  localparam logic [DATA_W-1:0] DMAX = DATA_W'(DATA_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE
  } state_e;

  state_e              state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                empty_s;
  logic [1:0]          mode_q;
  logic [15:0]         blen_q;
  logic [15:0]         bcnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                wr_en_q;
  logic                done_q;
  logic [31:0]         cnt_q;
  logic                ovf_q;
  logic                last_d;
  logic                stop_d;
  logic                run_d;

  function automatic logic [DATA_W-1:0] start_data(
    input logic [1:0] m
  );
    logic [DATA_W-1:0] r;
    r = '0;
    unique case (m)
      2'd0: r = '0;
      2'd1: r = DMAX;
      2'd2: r = DATA_W'(1);
      2'd3: r = PATTERN;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] next_data(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] r;
    r = d;
    unique case (m)
      2'd0: r = (d == DMAX) ? '0 : d + DATA_W'(1);
      2'd1: r = (d == '0) ? DMAX : d - DATA_W'(1);
      2'd2: r = {d[DATA_W-2:0], d[DATA_W-1]};
      2'd3: r = d;
    endcase
    return r;
  endfunction

  // empty lives in the read domain; only the last stage is used
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], empty};
    end
  end

  assign empty_s = sync_q[SYNC_STAGES-1];

  assign run_d  = enable & ~wr_rst_busy;
  assign last_d = (blen_q != 16'd0) &&
                  (16'(bcnt_q + 16'd1) == blen_q);
  assign stop_d = almost_full | full | last_d;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      blen_q  <= 16'd0;
      bcnt_q  <= 16'd0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 32'd0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_en_q) begin
        data_q <= next_data(mode_q, data_q);
        cnt_q  <= cnt_q + 32'd1;
        bcnt_q <= bcnt_q + 16'd1;
        if (full) begin
          ovf_q <= 1'b1;
        end
      end
      if (!run_d) begin
        state_q <= S_IDLE;
        wr_en_q <= 1'b0;
        if (state_q == S_WRITE) begin
          done_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q <= S_WAIT;
            mode_q  <= mode;
            blen_q  <= burst_len;
            data_q  <= start_data(mode);
          end
          S_WAIT: begin
            if (empty_s) begin
              state_q <= S_WRITE;
              wr_en_q <= 1'b1;
              bcnt_q  <= 16'd0;
            end
          end
          S_WRITE: begin
            if (stop_d) begin
              state_q <= S_WAIT;
              wr_en_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = data_q;
  assign busy         = (state_q != S_IDLE);
  assign burst_done   = done_q;
  assign word_cnt     = cnt_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Directed bench for fifo_wr_gen with hand-computed write sequences.
// Default parameters: DATA_W 8, SYNC_STAGES 2, DATA_MAX 254, PATTERN A5.
module tb_fifo_wr_gen;

  logic        wr_clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] burst_len;
  logic        wr_rst_busy;
  logic        empty;
  logic        almost_full;
  logic        full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        busy;
  logic        burst_done;
  logic [31:0] word_cnt;
  logic        overflow_err;

  int nchk;
  int npass;
  int bd_cnt;
  logic [7:0] got_q[$];

  fifo_wr_gen dut (
    .wr_clk       (wr_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode         (mode),
    .burst_len    (burst_len),
    .wr_rst_busy  (wr_rst_busy),
    .empty        (empty),
    .almost_full  (almost_full),
    .full         (full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .burst_done   (burst_done),
    .word_cnt     (word_cnt),
    .overflow_err (overflow_err)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got === exp) begin
      npass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // collect writes at negedges until n are captured or budget expires
  task automatic run_until(input int n, input int maxc);
    int c;
    c = 0;
    while (got_q.size() < n && c < maxc) begin
      @(negedge wr_clk);
      c++;
      if (burst_done) bd_cnt++;
      if (fifo_wr_en) got_q.push_back(fifo_wr_data);
    end
    if (got_q.size() < n) chk("timeout", got_q.size(), n);
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", fifo_wr_data, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_ovf", overflow_err, 0);
    @(negedge wr_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge wr_clk);
    got_q.delete();
    bd_cnt = 0;
  endtask

  initial begin
    logic [7:0] walk [10];
    int n;
    nchk = 0; npass = 0; bd_cnt = 0;
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; burst_len = 16'd0;
    wr_rst_busy = 1'b0; empty = 1'b1; almost_full = 1'b0; full = 1'b0;
    repeat (2) @(negedge wr_clk);
    do_reset();

    // increment, unlimited burst, stopped by almost_full
    mode = 2'd0; burst_len = 16'd0; enable = 1'b1;
    run_until(256, 400);
    almost_full = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("inc_%0d", i), got_q[i], (i == 255) ? 0 : i);
    end
    @(negedge wr_clk);
    chk("af_wr_en", fifo_wr_en, 0);
    chk("af_done", burst_done, 1);
    chk("af_busy", busy, 1);
    enable = 1'b0; almost_full = 1'b0;
    @(negedge wr_clk);
    chk("af_idle", busy, 0);
    chk("af_cnt", word_cnt, 256);

    // decrement, bursts of 4; mid-run mode/len changes ignored
    got_q.delete(); bd_cnt = 0;
    mode = 2'd1; burst_len = 16'd4; enable = 1'b1;
    run_until(2, 20);
    mode = 2'd0; burst_len = 16'd1;
    run_until(8, 40);
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("dec_%0d", i), got_q[i], 254 - i);
    end
    chk("dec_bd_first", bd_cnt, 1);
    @(negedge wr_clk);
    chk("dec_bd_last", burst_done, 1);
    chk("dec_idle", busy, 0);
    chk("dec_cnt", word_cnt, 264);

    // walking one, burst of 10
    do_reset();
    mode = 2'd2; burst_len = 16'd10; enable = 1'b1;
    run_until(10, 40);
    enable = 1'b0;
    walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
             8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("walk_%0d", i), got_q[i], walk[i]);
    end
    @(negedge wr_clk);
    chk("walk_done", burst_done, 1);
    chk("walk_wr_en", fifo_wr_en, 0);
    chk("walk_cnt", word_cnt, 10);

    // empty synchroniser latency, fixed pattern
    empty = 1'b0;
    do_reset();
    mode = 2'd3; burst_len = 16'd2; enable = 1'b1;
    repeat (4) @(negedge wr_clk);
    chk("sync_wait_busy", busy, 1);
    chk("sync_wait_wr_en", fifo_wr_en, 0);
    empty = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge wr_clk);
      n++;
      #1;
      if (n == 1) empty = 1'b0;
      if (fifo_wr_en) break;
    end
    chk("sync_latency", n, 3);
    run_until(2, 10);
    enable = 1'b0;
    chk("fix_0", got_q[0], 8'hA5);
    chk("fix_1", got_q[1], 8'hA5);
    @(negedge wr_clk);
    chk("fix_cnt", word_cnt, 2);

    // full during write -> sticky overflow
    empty = 1'b1;
    do_reset();
    full = 1'b1;
    repeat (2) @(negedge wr_clk);
    chk("full_idle_ovf", overflow_err, 0);
    full = 1'b0;
    mode = 2'd0; burst_len = 16'd0; enable = 1'b1;
    run_until(3, 20);
    full = 1'b1;
    @(negedge wr_clk);
    chk("full_wr_en", fifo_wr_en, 0);
    chk("full_ovf", overflow_err, 1);
    chk("full_done", burst_done, 1);
    full = 1'b0; enable = 1'b0;
    repeat (3) @(negedge wr_clk);
    chk("full_ovf_sticky", overflow_err, 1);
    chk("full_cnt", word_cnt, 3);
    do_reset();

    // wr_rst_busy abort and restart reload
    mode = 2'd0; burst_len = 16'd0; enable = 1'b1;
    run_until(3, 20);
    wr_rst_busy = 1'b1;
    @(negedge wr_clk);
    chk("wrb_wr_en", fifo_wr_en, 0);
    chk("wrb_busy", busy, 0);
    chk("wrb_done", burst_done, 1);
    chk("wrb_cnt", word_cnt, 3);
    wr_rst_busy = 1'b0;
    got_q.delete();
    run_until(2, 20);
    chk("wrb_reload_0", got_q[0], 0);
    chk("wrb_reload_1", got_q[1], 1);

    // asynchronous reset mid-burst
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_wr_en", fifo_wr_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", word_cnt, 0);
    @(negedge wr_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge wr_clk);
    chk("arst_idle", busy, 0);
    chk("arst_no_wr", fifo_wr_en, 0);
    got_q.delete();
    mode = 2'd1; burst_len = 16'd0; enable = 1'b1;
    run_until(1, 20);
    chk("arst_reload", got_q[0], 254);
    enable = 1'b0;
    @(negedge wr_clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
